// File: rtl/color_hex_scroller.sv
// color_hex_scroller
//   Filters the classifier's 2-bit color code so only a stable code reaches
//   the display. Drives NUM_DIGITS active-low seven-segment digits with the
//   color word, shown static, scrolling or blinking.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   sample_valid      color_in is valid this cycle
//   color_in[1:0]     0 red, 1 green, 2 blue, 3 none
//   mode[1:0]         0 static, 1 scroll, 2 blink, 3 off
//   hex_out           7 bits per digit, active-low, digit NUM_DIGITS-1 leftmost
//   shown_color[1:0]  color currently displayed
//   changed           one-cycle pulse after shown_color changes
module color_hex_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 25_000_000,
  parameter int STABLE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_valid,
  input  logic [1:0]              color_in,
  input  logic [1:0]              mode,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [1:0]              shown_color,
  output logic                    changed
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam int TW = $clog2(TICK_DIV);

  localparam logic [6:0] G_R  = 7'b0101111;
  localparam logic [6:0] G_E  = 7'b0000110;
  localparam logic [6:0] G_D  = 7'b0100001;
  localparam logic [6:0] G_G  = 7'b1000010;
  localparam logic [6:0] G_N  = 7'b0101011;
  localparam logic [6:0] G_B  = 7'b0000011;
  localparam logic [6:0] G_L  = 7'b1000111;
  localparam logic [6:0] G_U  = 7'b1100011;
  localparam logic [6:0] G_DA = 7'b0111111;
  localparam logic [6:0] G_BL = 7'b1111111;

  // Message ROM: 8 slots per color, left-justified, blank-padded.
  function automatic logic [6:0] glyph(input logic [1:0] c, input logic [2:0] s);
    logic [6:0] g;
    g = G_BL;
    case (c)
      2'd0: case (s)
              3'd0: g = G_R;
              3'd1: g = G_E;
              3'd2: g = G_D;
              default: g = G_BL;
            endcase
      2'd1: case (s)
              3'd0: g = G_G;
              3'd1: g = G_R;
              3'd2: g = G_E;
              3'd3: g = G_E;
              3'd4: g = G_N;
              default: g = G_BL;
            endcase
      2'd2: case (s)
              3'd0: g = G_B;
              3'd1: g = G_L;
              3'd2: g = G_U;
              3'd3: g = G_E;
              default: g = G_BL;
            endcase
      default: g = G_DA;
    endcase
    return g;
  endfunction

  logic [1:0]              cand_q, cand_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [1:0]              shown_q, shown_d;
  logic                    changed_q, changed_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [2:0]              offs_q, offs_d;
  logic                    phase_q, phase_d;
  logic [1:0]              mode_prev_q;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    tick, color_chg, restart;

  always_comb begin
    // stability filter
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sample_valid) begin
      if (color_in == cand_q) begin
        if (cnt_q != CW'(STABLE_CNT)) cnt_d = cnt_q + CW'(1);
      end else begin
        cand_d = color_in;
        cnt_d  = CW'(1);
      end
    end
    shown_d = shown_q;
    if (cnt_d == CW'(STABLE_CNT) && cand_d != shown_q) shown_d = cand_d;
    color_chg = (shown_d != shown_q);
    changed_d = color_chg;

    // rate tick and display state
    tick    = (tcnt_q == TW'(TICK_DIV - 1));
    restart = color_chg || (mode != mode_prev_q);
    tcnt_d  = tick ? '0 : tcnt_q + TW'(1);
    offs_d  = offs_q;
    phase_d = phase_q;
    case (mode)
      2'd0: begin
        offs_d  = 3'd0;
        phase_d = 1'b1;
      end
      2'd1: if (tick) offs_d = offs_q + 3'd1;
      2'd2: if (tick) phase_d = ~phase_q;
      default: ;
    endcase
    // restart outranks a coincident tick
    if (restart) begin
      tcnt_d  = '0;
      offs_d  = 3'd0;
      phase_d = 1'b1;
    end

    // output mapping uses the current registered state (1-cycle latency)
    hex_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!(mode == 2'd3 || (mode == 2'd2 && !phase_q)))
        hex_d[7*k +: 7] = glyph(shown_q, offs_q + 3'(NUM_DIGITS - 1 - k));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q      <= 2'd3;
      cnt_q       <= '0;
      shown_q     <= 2'd3;
      changed_q   <= 1'b0;
      tcnt_q      <= '0;
      offs_q      <= 3'd0;
      phase_q     <= 1'b1;
      mode_prev_q <= 2'd0;
      hex_q       <= '1;
    end else begin
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      shown_q     <= shown_d;
      changed_q   <= changed_d;
      tcnt_q      <= tcnt_d;
      offs_q      <= offs_d;
      phase_q     <= phase_d;
      mode_prev_q <= mode;
      hex_q       <= hex_d;
    end
  end

  assign hex_out     = hex_q;
  assign shown_color = shown_q;
  assign changed     = changed_q;

endmodule

// File: tb/tb_color_hex_scroller.sv
module tb_color_hex_scroller;

  localparam logic [6:0] GR = 7'b0101111, GE = 7'b0000110, GD = 7'b0100001;
  localparam logic [6:0] GG = 7'b1000010, GN = 7'b0101011, GB = 7'b0000011;
  localparam logic [6:0] GL = 7'b1000111, GU = 7'b1100011, GDA = 7'b0111111;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [41:0] ALL_BL = {6{BL}};
  localparam logic [41:0] DASHES = {6{GDA}};
  localparam logic [41:0] W_RED  = {GR, GE, GD, BL, BL, BL};
  localparam logic [41:0] W_GRN  = {GG, GR, GE, GE, GN, BL};
  localparam logic [41:0] W_BLU  = {GB, GL, GU, GE, BL, BL};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [1:0]  color_in = 2'd0;
  logic [1:0]  mode = 2'd0;
  logic [41:0] hex_out;
  logic [1:0]  shown_color;
  logic        changed;

  int checks = 0;
  int errors = 0;

  color_hex_scroller #(.NUM_DIGITS(6), .TICK_DIV(4), .STABLE_CNT(3)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
    .color_in(color_in), .mode(mode), .hex_out(hex_out),
    .shown_color(shown_color), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode = 2'd0; sample_valid = 1'b0;
    repeat (2) step();
    checks++; if (hex_out !== ALL_BL) begin errors++; $display("FAIL reset_hex: got %h exp %h", hex_out, ALL_BL); end
    checks++; if (shown_color !== 2'd3) begin errors++; $display("FAIL reset_shown: got %0d exp 3", shown_color); end
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b exp 0", changed); end
    reset_n = 1'b1;
    step();
    checks++; if (hex_out !== DASHES) begin errors++; $display("FAIL reset_dashes1: got %h exp %h", hex_out, DASHES); end
    step();
    checks++; if (hex_out !== DASHES) begin errors++; $display("FAIL reset_dashes2: got %h exp %h", hex_out, DASHES); end
    checks++; if (shown_color !== 2'd3 || changed !== 1'b0) begin errors++; $display("FAIL post_reset_state: got shown %0d changed %b exp 3 0", shown_color, changed); end
  endtask

  task automatic test_red();
    sample_valid = 1'b1; color_in = 2'd0;
    step(); step();
    checks++; if (shown_color !== 2'd3 || changed !== 1'b0) begin errors++; $display("FAIL red_early: got shown %0d changed %b exp 3 0", shown_color, changed); end
    step();
    checks++; if (shown_color !== 2'd0 || changed !== 1'b1) begin errors++; $display("FAIL red_change: got shown %0d changed %b exp 0 1", shown_color, changed); end
    sample_valid = 1'b0;
    step();
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL red_pulse_len: got %b exp 0", changed); end
    checks++; if (hex_out !== W_RED) begin errors++; $display("FAIL red_word: got %h exp %h", hex_out, W_RED); end
  endtask

  task automatic test_filter();
    logic [1:0] seq [5] = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      color_in = seq[i];
      step();
      checks++; if (shown_color !== 2'd0 || changed !== 1'b0) begin errors++; $display("FAIL filter_hold%0d: got shown %0d changed %b exp 0 0", i, shown_color, changed); end
    end
    color_in = 2'd1;
    step();
    checks++; if (shown_color !== 2'd1 || changed !== 1'b1) begin errors++; $display("FAIL filter_change: got shown %0d changed %b exp 1 1", shown_color, changed); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (changed !== 1'b0 || shown_color !== 2'd1) begin errors++; $display("FAIL filter_repeat%0d: got shown %0d changed %b exp 1 0", i, shown_color, changed); end
    end
    checks++; if (hex_out !== W_GRN) begin errors++; $display("FAIL green_word: got %h exp %h", hex_out, W_GRN); end
    sample_valid = 1'b0;
  endtask

  task automatic test_scroll();
    logic [6:0] lm [8] = '{GG, GR, GE, GE, GN, BL, BL, BL};
    mode = 2'd1;
    step();
    step(); step();
    checks++; if (hex_out !== W_GRN) begin errors++; $display("FAIL scroll_s0: got %h exp %h", hex_out, W_GRN); end
    for (int s = 1; s <= 8; s++) begin
      repeat (4) step();
      checks++; if (hex_out[41:35] !== lm[s % 8]) begin errors++; $display("FAIL scroll_left%0d: got %b exp %b", s, hex_out[41:35], lm[s % 8]); end
      if (s == 7) begin
        checks++; if (hex_out !== {BL, GG, GR, GE, GE, GN}) begin errors++; $display("FAIL scroll_s7: got %h exp %h", hex_out, {BL, GG, GR, GE, GE, GN}); end
      end
    end
  endtask

  task automatic test_blink();
    mode = 2'd0; sample_valid = 1'b1; color_in = 2'd2;
    repeat (3) step();
    sample_valid = 1'b0;
    step();
    checks++; if (shown_color !== 2'd2) begin errors++; $display("FAIL blue_shown: got %0d exp 2", shown_color); end
    mode = 2'd2;
    step();                       // M
    step(); step();               // M+2
    checks++; if (hex_out !== W_BLU) begin errors++; $display("FAIL blink_on1: got %h exp %h", hex_out, W_BLU); end
    repeat (4) step();            // M+6
    checks++; if (hex_out !== ALL_BL) begin errors++; $display("FAIL blink_off1: got %h exp %h", hex_out, ALL_BL); end
    repeat (4) step();            // M+10
    checks++; if (hex_out !== W_BLU) begin errors++; $display("FAIL blink_on2: got %h exp %h", hex_out, W_BLU); end
    repeat (3) step();            // M+13
    checks++; if (hex_out !== ALL_BL) begin errors++; $display("FAIL blink_off2: got %h exp %h", hex_out, ALL_BL); end
    sample_valid = 1'b1; color_in = 2'd0;
    step(); step();               // M+15
    checks++; if (hex_out !== ALL_BL || shown_color !== 2'd2) begin errors++; $display("FAIL blink_pre_red: got %h shown %0d exp %h 2", hex_out, shown_color, ALL_BL); end
    step();                       // M+16: change coincides with tick
    checks++; if (shown_color !== 2'd0 || changed !== 1'b1) begin errors++; $display("FAIL blink_red_chg: got shown %0d changed %b exp 0 1", shown_color, changed); end
    sample_valid = 1'b0;
    step();                       // M+17
    checks++; if (hex_out !== W_RED || changed !== 1'b0) begin errors++; $display("FAIL blink_red_on: got %h changed %b exp %h 0", hex_out, changed, W_RED); end
    repeat (3) step();            // M+20
    checks++; if (hex_out !== W_RED) begin errors++; $display("FAIL blink_red_hold: got %h exp %h", hex_out, W_RED); end
    step();                       // M+21
    checks++; if (hex_out !== ALL_BL) begin errors++; $display("FAIL blink_red_off: got %h exp %h", hex_out, ALL_BL); end
  endtask

  task automatic test_off();
    mode = 2'd3; sample_valid = 1'b1; color_in = 2'd1;
    step();
    checks++; if (hex_out !== ALL_BL) begin errors++; $display("FAIL off_blank: got %h exp %h", hex_out, ALL_BL); end
    step(); step();
    checks++; if (shown_color !== 2'd1 || changed !== 1'b1 || hex_out !== ALL_BL) begin errors++; $display("FAIL off_change: got shown %0d changed %b hex %h exp 1 1 %h", shown_color, changed, hex_out, ALL_BL); end
    sample_valid = 1'b0;
    step();
    checks++; if (changed !== 1'b0 || hex_out !== ALL_BL) begin errors++; $display("FAIL off_after: got changed %b hex %h exp 0 %h", changed, hex_out, ALL_BL); end
  endtask

  task automatic test_reset_mid();
    mode = 2'd1;
    repeat (6) step();            // offs = 1 visible
    checks++; if (hex_out[41:35] !== GR) begin errors++; $display("FAIL mid_scroll: got %b exp %b", hex_out[41:35], GR); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (hex_out !== ALL_BL || shown_color !== 2'd3 || changed !== 1'b0) begin errors++; $display("FAIL async_reset: got hex %h shown %0d changed %b exp %h 3 0", hex_out, shown_color, changed, ALL_BL); end
    step();
    reset_n = 1'b1;
    step();
    checks++; if (hex_out !== DASHES) begin errors++; $display("FAIL rst_dashes: got %h exp %h", hex_out, DASHES); end
    sample_valid = 1'b1; color_in = 2'd1;
    repeat (3) step();
    checks++; if (shown_color !== 2'd1 || changed !== 1'b1) begin errors++; $display("FAIL rst_green: got shown %0d changed %b exp 1 1", shown_color, changed); end
    sample_valid = 1'b0;
    step();
    checks++; if (hex_out[41:35] !== GG) begin errors++; $display("FAIL rst_scroll0: got %b exp %b", hex_out[41:35], GG); end
    repeat (3) step();
    checks++; if (hex_out[41:35] !== GG) begin errors++; $display("FAIL rst_scroll0b: got %b exp %b", hex_out[41:35], GG); end
    step();
    checks++; if (hex_out[41:35] !== GR) begin errors++; $display("FAIL rst_scroll1: got %b exp %b", hex_out[41:35], GR); end
  endtask

  initial begin
    test_reset();
    test_red();
    test_filter();
    test_scroll();
    test_blink();
    test_off();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_hex_scroller.md
# color_hex_scroller

Parametrised successor to the dominant-color hex display. It filters the classifier's 2-bit color code so that only a stable code reaches the display, then drives NUM_DIGITS active-low seven-segment digits with the color word. The word can be shown static, scrolling or blinking. It sits between the color classifier and the board HEX pins.

## Interface

Parameters:
- NUM_DIGITS, default 6: digits driven; legal range 1..8.
- TICK_DIV, default 25_000_000: clock cycles per scroll step or blink phase; must be ≥ 2.
- STABLE_CNT, default 4: number of consecutive identical samples required before the shown color changes; must be ≥ 1.

Ports:
- clk, input, 1: the single clock.
- reset_n, input, 1: reset, asynchronous and active-low.
- sample_valid, input, 1: color_in is valid this cycle.
- color_in, input, 2: code 0 = red, 1 = green, 2 = blue, 3 = none.
- mode, input, 2: 0 = static, 1 = scroll, 2 = blink, 3 = off.
- hex_out, output, 7*NUM_DIGITS: segment bits, active-low. Bits [7k+6:7k] are digit k; digit NUM_DIGITS-1 is leftmost. Within a digit, bit 0 = segment a and bit 6 = segment g.
- shown_color, output, 2: color currently displayed.
- changed, output, 1: one-cycle pulse when shown_color changes.

## Operation

Message ROM, 8 character slots per color, left-justified and blank-padded:
- red: r E d followed by 5 blanks.
- green: G r E E n followed by 3 blanks.
- blue: b L u E followed by 4 blanks.
- none: 8 dashes.

Glyphs:
- r = 0101111, E = 0000110, d = 0100001, G = 1000010, n = 0101011.
- b = 0000011, L = 1000111, u = 1100011, dash = 0111111, blank = 1111111.

Stability filter, which uses registers cand (2 bits) and cnt (saturating, 0..STABLE_CNT):
- On a sample_valid cycle where color_in == cand: cnt increments and saturates at STABLE_CNT.
- On a sample_valid cycle where color_in != cand: cand ← color_in and cnt ← 1.
- Cycles with sample_valid = 0 leave cand and cnt unchanged.
- On the edge where the updated cnt equals STABLE_CNT and the updated cand ≠ shown_color: shown_color ← cand.
- One cycle later, changed = 1. It is a registered pulse of exactly one cycle.

Rate tick:
- tcnt counts 0..TICK_DIV-1 and wraps.
- tick is asserted when tcnt == TICK_DIV-1.

Display state is offs (3 bits, 0..7) and phase (1 = on):
- mode 0: offs = 0, phase = 1.
- mode 1: offs ← (offs+1) mod 8 on each tick.
- mode 2: phase toggles on each tick.
- mode 3: hex_out is all blank. The filter, shown_color and changed continue to operate.
- When mode differs from its value on the previous cycle: offs ← 0, phase ← 1, tcnt ← 0.
- When shown_color changes: offs ← 0, phase ← 1, tcnt ← 0. This has priority over a simultaneous tick.

Output mapping:
- Leftmost-relative position j = NUM_DIGITS-1-k shows message slot (offs + j) mod 8.
- In mode 2 with phase = 0, every digit is blank.

## Timing

Reset values (reset_n low, asynchronous):
- hex_out all 1 (blank).
- shown_color = 3, cand = 3, cnt = 0.
- offs = 0, phase = 1, tcnt = 0.
- changed = 0.

After reset release:
- The first clock edge loads the dashes of the "none" message into hex_out.
- hex_out is registered. It reflects shown_color, offs, phase and mode with 1 cycle of latency.

Latencies:
- Color change: the STABLE_CNT-th consecutive matching sample is clocked in at edge E. shown_color updates at E. changed is high for the cycle after E. The new word appears on hex_out at E+1.
- Scroll: the offs update happens at the tick edge, and hex_out shifts one cycle later. One full cycle of the message takes 8·TICK_DIV clocks.

Boundary cases:
- A sample that differs from cand restarts the count at 1, even if it equals shown_color. A sample equal to shown_color never pulses changed.
- STABLE_CNT = 1: any valid sample that differs from shown_color updates the display on that edge.
- reset_n asserted mid-scroll or mid-blink: all state returns to the reset values immediately, without waiting for a clock edge.

## Test plan

All scenarios use NUM_DIGITS = 6, TICK_DIV = 4 and STABLE_CNT = 3.

- Reset with mode 0, then hold reset_n high for 2 clocks -> hex_out is all 1 during reset, then six dashes (0111111); shown_color = 3; changed = 0.
- Three consecutive valid samples of 0 -> shown_color = 0 at the third edge; changed is high for exactly 1 cycle; hex_out from left to right = r E d blank blank blank.
- Samples 1, 1, 2, 1, 1, 1 -> no change until the sixth sample; then shown_color = 1 and a single changed pulse. Repeating samples of 1 afterwards produce no further pulse.
- mode 1 with green shown -> every 4 clocks the leftmost digit steps G, r, E, E, n, blank, blank, blank, then back to G. On the wrap, offs returns from 7 to 0.
- mode 2 with blue shown -> b L u E blank blank for 4 clocks, all blank for 4 clocks, repeating. A color change to red mid-blank restarts with r E d visible. mode 3 -> all blank while changed still pulses.
- reset_n pulsed low asynchronously mid-scroll -> outputs return to the reset values without a clock edge; the scroll restarts at offs = 0.
